cpu_run_controller: RTL and testbench

- Synthesisable run controller that sequences a RISC-V core through reset, run and completion.
- Holds the core's active-high reset for a programmable number of cycles, then releases it.
- While the core runs, counts cycles and watches the core's `out` bus. Ends the run on a pass value, on output stability, or on a cycle-budget timeout.
- Sits between the top-level clock/reset and the CPU, replacing fixed-delay reset and fixed-length clocking with parametrised, observable run control.

---
 rtl/cpu_run_ctrl_pkg.sv | 14 +
 rtl/run_stable_detector.sv | 39 +++
 rtl/cpu_run_controller.sv | 118 +++++++++++
 tb/tb_cpu_run_controller.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
// Optional build macro: CPU_RUN_CTRL_SIGNATURE_EN (see cpu_run_controller).
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } run_state_t;

  localparam logic [31:0] PASS_VALUE_DEF = 32'h0000_0001;

endpackage

// File: rtl/run_stable_detector.sv
// Tracks how many consecutive cycles the watched bus has held its value.
// stable asserts once STABLE_CYCLES-1 unchanged samples have been seen.
module run_stable_detector #(
  parameter int DATA_WIDTH    = 32,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  stable
);

  localparam int SW = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SW-1:0] LAST = SW'(STABLE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] prev;
  logic [SW-1:0]         cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev <= '0;
      cnt  <= '0;
    end else if (clear) begin
      prev <= data;
      cnt  <= '0;
    end else if (enable) begin
      prev <= data;
      if (data != prev)
        cnt <= '0;
      else if (cnt != LAST)
        cnt <= cnt + SW'(1);
    end
  end

  assign stable = (cnt == LAST);

endmodule

// File: rtl/cpu_run_controller.sv
// Sequences a RISC-V core through reset hold, run and completion.
// Define CPU_RUN_CTRL_SIGNATURE_EN to add the running output signature.
module cpu_run_controller
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int RESET_CYCLES  = 5,
  parameter int MAX_CYCLES    = 50,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_WIDTH     = 16,
  parameter logic [DATA_WIDTH-1:0] PASS_VALUE =
    DATA_WIDTH'(PASS_VALUE_DEF)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cpu_out,
  output logic                  cpu_reset,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [1:0]            state
`ifdef CPU_RUN_CTRL_SIGNATURE_EN
  ,
  output logic [DATA_WIDTH-1:0] signature
`endif
);

  localparam int HW = $clog2(RESET_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'(MAX_CYCLES - 1);

  run_state_t    st, nx;
  logic [HW-1:0] hold;
  logic          stable;
  logic          is_pass;
  logic          at_max;
  logic          enter_hold;
  logic          enter_run;

  assign is_pass    = (cpu_out == PASS_VALUE);
  assign at_max     = (cycle_count == CNT_LAST);
  assign enter_hold = (nx == RESET_HOLD) && (st != RESET_HOLD);
  assign enter_run  = (st == RESET_HOLD) && (nx == RUN);

  run_stable_detector #(
    .DATA_WIDTH    (DATA_WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stable (
    .clock  (clock),
    .reset  (reset),
    .clear  (enter_run),
    .enable (st == RUN),
    .data   (cpu_out),
    .stable (stable)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= IDLE;
    else        st <= nx;
  end

  always_comb begin
    nx = st;
    unique case (st)
      IDLE:       if (start) nx = RESET_HOLD;
      RESET_HOLD: if (hold == HOLD_LAST) nx = RUN;
      RUN:        if (is_pass || stable || at_max) nx = DONE;
      DONE:       if (start) nx = RESET_HOLD;
      default:    nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold        <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
    end else if (enter_hold) begin
      hold        <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
    end else if (st == RESET_HOLD) begin
      hold <= hold + HW'(1);
    end else if (st == RUN) begin
      // The exiting cycle keeps its count so DONE reports it.
      if (nx == DONE) begin
        pass    <= is_pass;
        timeout <= !is_pass && !stable && at_max;
      end else if (cycle_count != '1) begin
        cycle_count <= cycle_count + CNT_WIDTH'(1);
      end
    end
  end

`ifdef CPU_RUN_CTRL_SIGNATURE_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      signature <= '0;
    else if (enter_hold)
      signature <= '0;
    else if (st == RUN)
      signature <= {signature[DATA_WIDTH-2:0],
                    signature[DATA_WIDTH-1]} ^ cpu_out;
  end
`endif

  assign cpu_reset = (st != RUN);
  assign running   = (st == RUN);
  assign done      = (st == DONE);
  assign state     = st;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: reference model plus directed runs.
// Signature checks build only with CPU_RUN_CTRL_SIGNATURE_EN defined.
module tb_cpu_run_controller;

  localparam int DW = 32;
  localparam int RC = 5;
  localparam int MC = 50;
  localparam int SC = 8;
  localparam int CW = 16;
  localparam logic [DW-1:0] PV = 32'h0000_0001;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cpu_out = '0;
  logic          cpu_reset, running, done, pass, timeout;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state;
`ifdef CPU_RUN_CTRL_SIGNATURE_EN
  logic [DW-1:0] signature;
`endif

  cpu_run_controller dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .cpu_out     (cpu_out),
    .cpu_reset   (cpu_reset),
    .running     (running),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .state       (state)
`ifdef CPU_RUN_CTRL_SIGNATURE_EN
    ,
    .signature   (signature)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 holding, 2 running, 3 finished.
  int          m_ph   = 0;
  int          m_hold = 0;
  int          m_k    = 0;
  int          m_same = 0;
  logic [DW-1:0] m_prev = '0;
  logic [DW-1:0] m_sig  = '0;
  bit          m_pass = 0;
  bit          m_to   = 0;

  task automatic m_begin();
    m_ph = 1; m_hold = 0; m_k = 0;
    m_pass = 0; m_to = 0; m_sig = '0;
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ph = 0; m_hold = 0; m_k = 0; m_same = 0;
      m_prev = '0; m_sig = '0; m_pass = 0; m_to = 0;
    end else begin
      case (m_ph)
        0: if (start) m_begin();
        1: begin
          m_hold++;
          if (m_hold == RC) begin
            m_ph = 2; m_prev = cpu_out; m_same = 0;
          end
        end
        2: begin
          m_sig = {m_sig[DW-2:0], m_sig[DW-1]} ^ cpu_out;
          if (cpu_out == PV) begin
            m_ph = 3; m_pass = 1;
          end else if (m_same == SC - 1) begin
            m_ph = 3;
          end else if (m_k == MC - 1) begin
            m_ph = 3; m_to = 1;
          end else begin
            m_k++;
            m_same = (cpu_out == m_prev) ? m_same + 1 : 0;
            m_prev = cpu_out;
          end
        end
        default: if (start) m_begin();
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("state", state, m_ph);
      check("cpu_reset", cpu_reset, m_ph != 2);
      check("running", running, m_ph == 2);
      check("done", done, m_ph == 3);
      check("pass", pass, m_pass);
      check("timeout", timeout, m_to);
      check("cycle_count", cycle_count, m_k);
`ifdef CPU_RUN_CTRL_SIGNATURE_EN
      check("signature", signature, m_sig);
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (!running && n < 40) begin
      n++;
      tick();
    end
    if (!running) check("wait_run_bound", 0, 1);
  endtask

  int n;

  initial begin
    tick();
    chk_en = 1;
    tick();
    tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_state", state, 0);
    check("rst_count", cycle_count, 0);
    reset = 1'b1;
    tick();
    check("idle_cpu_reset", cpu_reset, 1);

    // Hold length and pass exit at run cycle 10
    cpu_out = 32'h100;
    do_start();
    wait_run(n);
    check("hold_len", n, RC);
    for (int k = 0; k < 10; k++) begin
      cpu_out = 32'h100 + DW'(k);
      check("count_seq", cycle_count, k);
      tick();
    end
    cpu_out = PV;
    tick();
    check("p_done", done, 1);
    check("p_pass", pass, 1);
    check("p_timeout", timeout, 0);
    check("p_count", cycle_count, 10);
    check("p_cpu_reset", cpu_reset, 1);
    cpu_out = 32'h0;
    tick();
    check("p_hold", pass, 1);

    // Restart from DONE clears flags
    do_start();
    check("rs_state", state, 1);
    check("rs_done", done, 0);
    check("rs_pass", pass, 0);
    check("rs_count", cycle_count, 0);

    // Toggling output runs into the budget; start in RUN ignored
    wait_run(n);
    n = 0;
    while (!done && n < 70) begin
      cpu_out = n[0] ? 32'h5A : 32'hA5;
      start = (n == 3);
      if (n == 4) check("run_ignore_start", state, 2);
      n++;
      tick();
    end
    start = 1'b0;
    check("to_run_len", n, MC);
    check("to_done", done, 1);
    check("to_timeout", timeout, 1);
    check("to_pass", pass, 0);
    check("to_count", cycle_count, MC - 1);

    // Constant output halts after 8 run cycles
    cpu_out = 32'hAA;
    do_start();
    wait_run(n);
    n = 0;
    while (!done && n < 20) begin
      n++;
      tick();
    end
    check("st_run_len", n, SC);
    check("st_pass", pass, 0);
    check("st_timeout", timeout, 0);
    check("st_count", cycle_count, SC - 1);

    // Pass wins over stability in the same cycle
    do_start();
    wait_run(n);
    for (int k = 0; k < SC - 1; k++) tick();
    cpu_out = PV;
    tick();
    check("pr_done", done, 1);
    check("pr_pass", pass, 1);
    check("pr_count", cycle_count, SC - 1);
    cpu_out = 32'h0;

    // Async reset mid-run
    do_start();
    wait_run(n);
    for (int k = 0; k < 20; k++) begin
      cpu_out = 32'h200 + DW'(k);
      tick();
    end
    check("ar_pre_running", running, 1);
    #2 reset = 1'b0;
    #1;
    check("ar_cpu_reset", cpu_reset, 1);
    check("ar_state", state, 0);
    check("ar_count", cycle_count, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    tick();
    check("ar_idle", state, 0);
    check("ar_pass", pass, 0);

`ifdef CPU_RUN_CTRL_SIGNATURE_EN
    cpu_out = 32'h0;
    do_start();
    wait_run(n);
    check("sig_clear", signature, 0);
    cpu_out = 32'd1;
    tick();
    cpu_out = 32'h100;
    tick();
    tick();
    cpu_out = 32'h0;
    do_start();
    wait_run(n);
    cpu_out = 32'd3;
    tick();
    cpu_out = 32'd2;
    tick();
    check("sig_a", signature, 32'h4);
    cpu_out = 32'h0;
    tick();
    do_start();
    wait_run(n);
    cpu_out = 32'd2;
    tick();
    cpu_out = 32'h0;
    check("sig_b", signature, 32'h2);
`endif

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
